// File: rtl/shift_add_mult_ctrl.sv
// Control FSM for a sequential signed shift-add multiplier.
// Sequences two shifters (multiplicand left, multiplier right) and an
// accumulator, tracks the result sign, counts iterations and stops early once
// the remaining multiplier is zero. Host handshake is start / busy / done.
module shift_add_mult_ctrl #(
    parameter int N     = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             a_sign,
    input  logic             b_sign,
    input  logic             mplier_lsb,
    input  logic             mplier_zero,
    output logic             mcand_load,
    output logic             mcand_shift,
    output logic             mcand_dir,
    output logic             mplier_load,
    output logic             mplier_shift,
    output logic             mplier_dir,
    output logic             acc_clr,
    output logic             acc_add,
    output logic             busy,
    output logic             done,
    output logic             neg_result,
    output logic [CNT_W-1:0] iter
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] ITER_MAX = CNT_W'(N);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] iter_q, iter_d;
    logic             neg_q, neg_d;

    logic run_exit;
    logic run_work;

    // The exit check wins over a work cycle; abort wins over both.
    assign run_exit = (state_q == S_RUN) && (mplier_zero || (iter_q == ITER_MAX));
    assign run_work = (state_q == S_RUN) && !abort && !run_exit;

    // Next-state, iteration count and sign latch.
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        neg_d   = neg_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    neg_d   = a_sign ^ b_sign;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    iter_d  = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (run_exit) begin
                    state_d = S_DONE;
                end else begin
                    iter_d = iter_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register, iteration counter and result sign, with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            iter_q  <= '0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            neg_q   <= neg_d;
        end
    end

    // Datapath strobes decoded from state; any abort cycle drives every enable low.
    always_comb begin
        mcand_load   = (state_q == S_LOAD) && !abort;
        mplier_load  = (state_q == S_LOAD) && !abort;
        acc_clr      = (state_q == S_LOAD) && !abort;
        mcand_shift  = run_work;
        mplier_shift = run_work;
        acc_add      = run_work && mplier_lsb;
        busy         = (state_q != S_IDLE);
        done         = (state_q == S_DONE) && !abort;
    end

    // The multiplicand always moves left and the multiplier always moves right.
    assign mcand_dir  = 1'b1;
    assign mplier_dir = 1'b0;

    assign iter       = iter_q;
    assign neg_result = neg_q;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Testbench for shift_add_mult_ctrl: models the shifters and accumulator
// around the controller, predicts every transaction from plain signed
// arithmetic and checks completions through a queue-based scoreboard.
module tb_shift_add_mult_ctrl;

    localparam int N     = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst, start, abort, a_sign, b_sign;
    logic             mplier_lsb, mplier_zero;
    logic             mcand_load, mcand_shift, mcand_dir;
    logic             mplier_load, mplier_shift, mplier_dir;
    logic             acc_clr, acc_add, busy, done, neg_result;
    logic [CNT_W-1:0] iter;

    shift_add_mult_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .a_sign(a_sign), .b_sign(b_sign),
        .mplier_lsb(mplier_lsb), .mplier_zero(mplier_zero),
        .mcand_load(mcand_load), .mcand_shift(mcand_shift), .mcand_dir(mcand_dir),
        .mplier_load(mplier_load), .mplier_shift(mplier_shift), .mplier_dir(mplier_dir),
        .acc_clr(acc_clr), .acc_add(acc_add), .busy(busy), .done(done),
        .neg_result(neg_result), .iter(iter)
    );

    always #5 clk = ~clk;

    // Datapath model: shifters and accumulator driven by the controller.
    logic [N-1:0]   a_mag = '0;
    logic [N-1:0]   b_mag = '0;
    logic [2*N-1:0] dp_mcand = '0;
    logic [2*N-1:0] dp_acc = '0;
    logic [N-1:0]   dp_mplier = '0;

    always @(posedge clk) begin
        if (mcand_load) dp_mcand <= {{N{1'b0}}, a_mag};
        else if (mcand_shift) dp_mcand <= dp_mcand << 1;
        if (mplier_load) dp_mplier <= b_mag;
        else if (mplier_shift) dp_mplier <= dp_mplier >> 1;
        if (acc_clr) dp_acc <= '0;
        else if (acc_add) dp_acc <= dp_acc + dp_mcand;
    end

    assign mplier_lsb  = dp_mplier[0];
    assign mplier_zero = (dp_mplier == '0);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard
    typedef struct {
        int           t_done;
        int           iter;
        bit           neg;
        int           prod;
        logic [N-1:0] pat;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    // Number of iterations: one per multiplier bit up to the highest set bit.
    function automatic int ref_k(input logic [N-1:0] b);
        int k = 0;
        for (int i = 0; i < N; i++) if (b[i]) k = i + 1;
        return k;
    endfunction

    function automatic int all_outs();
        return int'({busy, done, mcand_load, mcand_shift, mplier_load, mplier_shift,
                     acc_clr, acc_add, neg_result, iter});
    endfunction

    // Monitor: per-cycle invariants and scoreboard pops on done.
    logic [N-1:0] mon_pat = '0;
    int           mon_sh = 0;
    bit           post_done = 0;
    int           last_iter = 0;
    bit           last_neg = 0;

    always @(negedge clk) begin
        if (!rst) begin
            chk("invariants",
                int'({mcand_dir != 1'b1, mplier_dir != 1'b0,
                      mcand_load & mcand_shift, mplier_load & mplier_shift,
                      acc_add & ~mcand_shift, done & ~busy}), 0);
            if (post_done) begin
                chk("iter_hold_after_done", int'(iter), last_iter);
                chk("neg_hold_after_done", int'(neg_result), int'(last_neg));
                post_done = 0;
            end
            if (mcand_load) begin
                mon_pat = '0;
                mon_sh  = 0;
            end
            if (mcand_shift) begin
                if (acc_add && mon_sh < N) mon_pat[mon_sh] = 1'b1;
                mon_sh++;
            end
            if (done) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    int   prod;
                    e    = sb_q.pop_front();
                    prod = neg_result ? -int'(dp_acc) : int'(dp_acc);
                    chk("done_cycle", cyc, e.t_done);
                    chk("iter", int'(iter), e.iter);
                    chk("neg_result", int'(neg_result), int'(e.neg));
                    chk("product", prod, e.prod);
                    chk("add_pattern", int'(mon_pat), int'(e.pat));
                    chk("shift_count", mon_sh, e.iter);
                    post_done = 1;
                    last_iter = e.iter;
                    last_neg  = e.neg;
                end
            end
        end else begin
            post_done = 0;
        end
    end

    // Issue a start after a negedge while idle; push the predicted outcome.
    task automatic issue(input logic [N-1:0] a, input bit as, input logic [N-1:0] b,
                         input bit bs, input bit hold);
        exp_t e;
        int   sa, sb, k;
        a_mag  = a;
        b_mag  = b;
        a_sign = as;
        b_sign = bs;
        start  = 1'b1;
        k      = ref_k(b);
        sa     = as ? -int'(a) : int'(a);
        sb     = bs ? -int'(b) : int'(b);
        e.t_done = cyc + 1 + 2 + k;
        e.iter   = k;
        e.neg    = as ^ bs;
        e.prod   = sa * sb;
        e.pat    = b;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 40);
        chk("idle_within_bound", int'(busy), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; a_sign = 1'b0; b_sign = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset then idle
        repeat (5) begin
            @(negedge clk);
            chk("reset_idle_outputs", all_outs(), 0);
        end

        // Signed -3 x 5
        issue(8'd3, 1'b1, 8'd5, 1'b0, 1'b0);
        wait_idle();

        // Full-length run
        issue(8'h7F, 1'b1, 8'h80, 1'b1, 1'b0);
        wait_idle();

        // Zero multiplier
        issue(8'hA5, 1'b0, 8'h00, 1'b1, 1'b0);
        wait_idle();

        // Abort in the second RUN cycle, then immediate restart with 1 x 1
        issue(8'h11, 1'b0, 8'hFF, 1'b0, 1'b0);   // now in LOAD
        @(posedge clk); #1;                       // RUN 1
        @(posedge clk); #1;                       // RUN 2
        abort = 1'b1;
        @(negedge clk);
        chk("abort_cycle_enables",
            int'({mcand_load, mcand_shift, mplier_load, mplier_shift, acc_clr, acc_add, done}), 0);
        @(posedge clk); #1;
        abort = 1'b0;
        void'(sb_q.pop_back());
        @(negedge clk);
        chk("abort_next_busy", int'(busy), 0);
        chk("abort_next_done", int'(done), 0);
        chk("abort_iter_hold", int'(iter), 1);
        issue(8'd1, 1'b0, 8'd1, 1'b0, 1'b0);
        wait_idle();

        // Simultaneous start and abort in IDLE: start wins
        abort = 1'b1;
        issue(8'd9, 1'b0, 8'd6, 1'b1, 1'b0);
        abort = 1'b0;
        wait_idle();

        // start held high through the whole transaction including DONE
        issue(8'h2B, 1'b1, 8'h1D, 1'b1, 1'b1);
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!done && n < 40);
            chk("hold_start_done_seen", int'(done), 1);
        end
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("hold_start_then_idle", int'(busy), 0);

        // Reset pulsed mid-RUN
        issue(8'h33, 1'b1, 8'hF0, 1'b0, 1'b0);   // now in LOAD
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb_q.delete();
        @(negedge clk);
        chk("rst_mid_run_outputs", all_outs(), 0);

        // Randomized transactions
        for (int t = 0; t < 60; t++) begin
            logic [N-1:0] a, b;
            bit           as, bs, ab;
            a  = N'($urandom);
            b  = N'($urandom);
            case ($urandom_range(0, 3))
                0: b = b & 8'h07;
                1: b = '0;
                default: ;
            endcase
            as = bit'($urandom_range(0, 1));
            bs = bit'($urandom_range(0, 1));
            ab = ($urandom_range(0, 7) == 0);
            abort = ab;
            issue(a, as, b, bs, 1'b0);
            abort = 1'b0;
            wait_idle();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
